// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: sclk generation, per-channel 3rd-order CIC decimator and a valid/ready PCM register.
// Optional macro PDM_RX_OVF_EN builds the sticky overrun flag on ovf; otherwise ovf is tied low.
module pdm_mic_rx #(
    parameter int CLK_DIV    = 12,
    parameter int CHANNELS   = 1,
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      dat_i,
    output logic                      sclk,
    output logic [CHANNELS*OUT_W-1:0] pcm_data,
    output logic                      pcm_valid,
    input  logic                      pcm_ready,
    output logic                      ovf
);
    localparam int ACC_W = 3*DECIM_LOG2 + 2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DECIM_LOG2-1:0] DEC_LAST = {DECIM_LOG2{1'b1}};

    logic [DIV_W-1:0]          div_cnt_r;
    logic                      sclk_r;
    logic [DECIM_LOG2-1:0]     dec_cnt_r;
    logic                      frame_pend_r;
    logic [CHANNELS*OUT_W-1:0] pcm_data_r;
    logic                      pcm_valid_r;

    logic [ACC_W-1:0] integ1_r  [CHANNELS];
    logic [ACC_W-1:0] integ2_r  [CHANNELS];
    logic [ACC_W-1:0] integ3_r  [CHANNELS];
    logic [ACC_W-1:0] comb_d1_r [CHANNELS];
    logic [ACC_W-1:0] comb_d2_r [CHANNELS];
    logic [ACC_W-1:0] comb_d3_r [CHANNELS];

    logic [ACC_W-1:0] integ1_nx_s [CHANNELS];
    logic [ACC_W-1:0] integ2_nx_s [CHANNELS];
    logic [ACC_W-1:0] integ3_nx_s [CHANNELS];
    logic [ACC_W-1:0] comb1_s     [CHANNELS];
    logic [ACC_W-1:0] comb2_s     [CHANNELS];
    logic [ACC_W-1:0] comb3_s     [CHANNELS];
    logic             ev_s        [CHANNELS];

    logic                      wrap_s;
    logic [ACC_W-1:0]          samp_s;
    logic [CHANNELS*OUT_W-1:0] frame_s;
    logic [CHANNELS-1:0]       trunc_unused_s;
    logic                      load_s;
    logic                      accept_s;

    assign wrap_s   = (div_cnt_r == DIV_LAST);
    assign samp_s   = dat_i ? ACC_W'(1) : {ACC_W{1'b1}};
    assign load_s   = frame_pend_r & en;
    assign accept_s = pcm_valid_r & pcm_ready;

    // Sample events, integrator next values and the comb cascade (delay 1, computed from current state).
    always_comb begin
        frame_s        = {(CHANNELS*OUT_W){1'b0}};
        trunc_unused_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            // Channel 0 samples on the falling toggle of sclk, channel 1 on the rising toggle.
            ev_s[c]        = wrap_s & ((c == 0) ? sclk_r : ~sclk_r);
            integ1_nx_s[c] = integ1_r[c] + samp_s;
            integ2_nx_s[c] = integ2_r[c] + integ1_nx_s[c];
            integ3_nx_s[c] = integ3_r[c] + integ2_nx_s[c];
            comb1_s[c]     = integ3_r[c] - comb_d1_r[c];
            comb2_s[c]     = comb1_s[c] - comb_d2_r[c];
            comb3_s[c]     = comb2_s[c] - comb_d3_r[c];
            frame_s[c*OUT_W +: OUT_W] = comb3_s[c][ACC_W-1 -: OUT_W];
            trunc_unused_s[c] = ^comb3_s[c];
        end
    end

    // Bit clock divider; held idle with sclk low while disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sclk_r    <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sclk_r    <= ~sclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Integrators, decimation counter and comb delay lines.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            dec_cnt_r    <= {DECIM_LOG2{1'b0}};
            frame_pend_r <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                integ1_r[c]  <= {ACC_W{1'b0}};
                integ2_r[c]  <= {ACC_W{1'b0}};
                integ3_r[c]  <= {ACC_W{1'b0}};
                comb_d1_r[c] <= {ACC_W{1'b0}};
                comb_d2_r[c] <= {ACC_W{1'b0}};
                comb_d3_r[c] <= {ACC_W{1'b0}};
            end
        end else begin
            frame_pend_r <= ev_s[0] && (dec_cnt_r == DEC_LAST);
            if (ev_s[0]) begin
                dec_cnt_r <= dec_cnt_r + DECIM_LOG2'(1);
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (ev_s[c]) begin
                    integ1_r[c] <= integ1_nx_s[c];
                    integ2_r[c] <= integ2_nx_s[c];
                    integ3_r[c] <= integ3_nx_s[c];
                end
                if (frame_pend_r) begin
                    comb_d1_r[c] <= integ3_r[c];
                    comb_d2_r[c] <= comb1_s[c];
                    comb_d3_r[c] <= comb2_s[c];
                end
            end
        end
    end

    // Output register: a new frame always loads, even over an unaccepted one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_data_r  <= {(CHANNELS*OUT_W){1'b0}};
            pcm_valid_r <= 1'b0;
        end else if (load_s) begin
            pcm_data_r  <= frame_s;
            pcm_valid_r <= 1'b1;
        end else if (accept_s) begin
            pcm_valid_r <= 1'b0;
        end else begin
            pcm_valid_r <= pcm_valid_r;
        end
    end

`ifdef PDM_RX_OVF_EN
    logic ovf_r;

    // Sticky overrun: a load while the held frame is neither accepted nor empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (load_s && pcm_valid_r && !pcm_ready) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign sclk      = sclk_r;
    assign pcm_data  = pcm_data_r;
    assign pcm_valid = pcm_valid_r;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Bench for pdm_mic_rx: scoreboard against a direct-form CIC impulse-response model (mono),
// plus a stereo instance checking channel mapping and frame latency.
module tb_pdm_mic_rx;
    localparam int CLK_DIV = 12;
    localparam int R       = 64;
    localparam int NTAP    = 3*R - 2;
`ifdef PDM_RX_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, dat_i, pcm_ready;
    logic        sclk, pcm_valid, ovf;
    logic [15:0] pcm_data;
    logic        st_rst, st_en, st_dat, st_ready;
    logic        st_sclk, st_valid, st_ovf;
    logic [31:0] st_data;

    int          errors = 0;
    int          checks = 0;
    int          h [NTAP];
    int          xs[$];
    logic [15:0] exp_q[$];
    int          mode = 0;
    bit          hold = 1'b0;
    bit          ready_rand = 1'b0;
    bit          prev_sclk = 1'b0;
    int          frames_issued = 0;
    int          st_frames = 0;

    always #5 clk = ~clk;

    pdm_mic_rx #(.CLK_DIV(CLK_DIV), .CHANNELS(1), .DECIM_LOG2(6), .OUT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .dat_i(dat_i), .sclk(sclk),
        .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .ovf(ovf)
    );

    pdm_mic_rx #(.CLK_DIV(CLK_DIV), .CHANNELS(2), .DECIM_LOG2(6), .OUT_W(16)) dut_st (
        .clk(clk), .rst(st_rst), .en(st_en), .dat_i(st_dat), .sclk(st_sclk),
        .pcm_data(st_data), .pcm_valid(st_valid), .pcm_ready(st_ready), .ovf(st_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: y = sum h[k]*x[n-1-k] over the full sample history (zero before restart), then >>> 4.
    task automatic issue_bit(input bit b);
        int y;
        int n;
        xs.push_back(b ? 1 : -1);
        n = xs.size();
        if (n % R == 0) begin
            y = 0;
            for (int k = 0; k < NTAP; k++)
                if (n - 1 - k >= 0) y += h[k] * xs[n-1-k];
            if (hold && exp_q.size() > 0) exp_q.delete(0);
            exp_q.push_back(16'(y >>> 4));
            frames_issued++;
        end
    endtask

    function automatic bit gen_bit();
        case (mode)
            0:       return ($urandom & 32'd1) != 32'd0;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (xs.size() % 2) == 0;
        endcase
    endfunction

    // New mono bit on each sclk rise (held through the high phase); stereo data mirrors sclk.
    task automatic tick();
        bit b;
        @(posedge clk);
        #2;
        if (sclk && !prev_sclk) begin
            b = gen_bit();
            dat_i = b;
            issue_bit(b);
        end
        prev_sclk = sclk;
        st_dat = st_sclk;
        if (ready_rand) pcm_ready = ($urandom & 32'd1) != 32'd0;
    endtask

    task automatic run_frames(input int k);
        int target;
        int n;
        target = frames_issued + k;
        n = 0;
        while (frames_issued < target && n < k*2*CLK_DIV*R + 200) begin
            tick();
            n++;
        end
        if (frames_issued < target) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_issued, target);
        end
    endtask

    // Mono scoreboard monitor: every handshake pops one expected frame.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst && pcm_valid && pcm_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_extra: got 0x%0h, expected no frame", pcm_data);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", 64'(pcm_data), 64'(e));
                end
            end
        end
    end

    // Stereo monitor: latency from the completing falling sclk edge and steady channel mapping.
    initial begin
        int  falls = 0;
        int  cyc = 0;
        int  exp_rise = -1;
        bit  ps = 1'b0;
        bit  pv = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (st_rst) begin
                falls = 0;
                st_frames = 0;
            end else begin
                if (ps && !st_sclk) begin
                    falls++;
                    if (falls % R == 0) exp_rise = cyc + 1;
                end
                if (st_valid && !pv) begin
                    st_frames++;
                    check("st_latency", 64'(cyc), 64'(exp_rise));
                    if (st_frames >= 4) check("st_frame", 64'(st_data), 64'h0000_0000_C000_4000);
                end
            end
            ps = st_sclk;
            pv = st_valid;
        end
    end

    initial begin
        int n;
        int highs;
        for (int k = 0; k < NTAP; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a+b+c]++;

        rst = 1'b1; en = 1'b1; dat_i = 1'b0; pcm_ready = 1'b1;
        st_rst = 1'b1; st_en = 1'b1; st_dat = 1'b0; st_ready = 1'b1;
        repeat (5) tick();
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_valid", 64'(pcm_valid), 64'd0);
        check("rst_data", 64'(pcm_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        st_rst = 1'b0;

        n = 0;
        do begin tick(); n++; end while (!sclk && n < 100);
        check("first_rise", 64'(n), 64'd12);
        n = 0;
        do begin tick(); n++; end while (sclk && n < 100);
        do begin tick(); n++; end while (!sclk && n < 100);
        check("sclk_period", 64'(n), 64'd24);

        // Random data with random backpressure, then full scale, cancellation.
        mode = 0; ready_rand = 1'b1;
        run_frames(5);
        ready_rand = 1'b0; pcm_ready = 1'b1;
        mode = 1; run_frames(4);
        mode = 2; run_frames(4);
        mode = 3; run_frames(4);
        check("ovf_before", 64'(ovf), 64'd0);

        // Overrun: hold off the consumer for two frames.
        mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin tick(); n++; end
        pcm_ready = 1'b0;
        hold = 1'b1;
        run_frames(2);
        repeat (20) tick();
        check("ovr_valid", 64'(pcm_valid), 64'd1);
        check("ovr_ovf", 64'(ovf), 64'(OVF_EXP));
        hold = 1'b0;
        pcm_ready = 1'b1;
        run_frames(1);
        repeat (20) tick();
        check("ovf_sticky", 64'(ovf), 64'(OVF_EXP));

        // Disable mid-frame for 100 cycles; the model restarts with the DUT.
        mode = 1;
        repeat (300) tick();
        en = 1'b0;
        xs.delete();
        highs = 0;
        repeat (100) begin
            tick();
            if (sclk !== 1'b0) highs++;
        end
        check("dis_sclk", 64'(highs), 64'd0);
        en = 1'b1;
        run_frames(5);

        // Reset colliding with a frame load: 13 edges after the completing bit's sclk rise.
        mode = 0;
        run_frames(1);
        repeat (12) tick();
        rst = 1'b1;
        xs.delete();
        exp_q.delete();
        tick();
        check("rstld_valid", 64'(pcm_valid), 64'd0);
        check("rstld_data", 64'(pcm_data), 64'd0);
        check("rstld_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        run_frames(1);
        repeat (30) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("st_frames_seen", 64'(st_frames > 10), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdm_mic_rx.md
# pdm_mic_rx

Parametrised PDM microphone receiver for the speech front end. It generates the microphone bit clock `sclk` from the system clock and samples the 1-bit `dat_i` stream on one or two channels. Each channel is decimated through a 3rd-order CIC filter. Signed PCM frames are delivered to the feature-extraction stage over a valid/ready handshake.

## Interface
- `CLK_DIV`, 12: `clk` cycles per `sclk` half-period (50 MHz gives 2.083 MHz `sclk`); must be ≥ 2.
- `CHANNELS`, 1: 1 or 2; channel 1 is the second mic on the shared `dat_i` line.
- `DECIM_LOG2`, 6: log2 of the decimation ratio R (default R = 64).
- `OUT_W`, 16: PCM word width; must be ≤ ACC_W.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable.
- `dat_i`  in  1  PDM data from the microphone(s).
- `sclk`  out  1  microphone bit clock.
- `pcm_data`  out  CHANNELS*OUT_W  signed samples; channel 0 in the LSBs.
- `pcm_valid`  out  1  frame available.
- `pcm_ready`  in  1  consumer accepts the frame.
- `ovf`  out  1  sticky overrun flag.

## Operation
- **Clock divider.** A counter runs 0..CLK_DIV-1. `sclk` toggles each time the counter wraps.
- **Channel 0 sampling.** `dat_i` is sampled in the same cycle that `sclk` toggles 1→0 (data driven while high).
- **Channel 1 sampling.** When CHANNELS=2, `dat_i` is sampled in the same cycle that `sclk` toggles 0→1.
- **Bit mapping.** 1 maps to +1 and 0 maps to −1.
- **Accumulator width.** ACC_W = 3*DECIM_LOG2 + 2, two's complement. Integrator wrap-around is intended; no saturation anywhere.
- **Integrators.** Three cascaded integrators per channel update on that channel's sample event.
- **Decimation counter.** Counts 0..R-1 and advances on each channel-0 sample event.
- **Comb stage.** On the event where the counter wraps, the third-integrator value of every channel enters three cascaded comb stages with differential delay 1. All channels are decimated together.
- **Output word.** Each channel's output is comb bits [ACC_W-1 -: OUT_W] of the full-precision result.
  - Full-scale +1 input gives R³ → 2^(ACC_W-OUT_W-... ) scaling; with defaults, +16384 (0x4000).
  - Full-scale −1 input gives −16384 (0xC000).
- **Frame delivery (`en` = 1).**
  - When a new frame is produced and the output register is empty or being accepted this cycle, it loads the register and `pcm_valid` = 1.
  - A transfer occurs when `pcm_valid` and `pcm_ready` are both high. `pcm_valid` drops the next cycle unless a new frame loads in that same cycle.
  - A new frame arriving while `pcm_valid` = 1 and `pcm_ready` = 0 overwrites `pcm_data`, keeps `pcm_valid` = 1 and sets `ovf` (see Configuration).
- **Disable (`en` = 0).** Takes effect the next cycle.
  - `sclk` is forced 0 and the divider, decimation counter and all integrator/comb state are cleared.
  - A pending frame stays valid until accepted.
  - On re-enable, sampling restarts from the reset state.
- **Settling.** The first 3 frames after reset or re-enable are CIC transients. Frames from the 4th onward are steady-state.

## Timing
- **Reset values.** `sclk`=0, `pcm_data`=0, `pcm_valid`=0, `ovf`=0; all counters and filter state are 0.
- **Reset mid-operation.** Takes effect on the next edge, overriding all other activity, including a frame load or handshake in the same cycle.
- **First edge.** The first `sclk` rising edge occurs CLK_DIV cycles after reset release with `en` = 1.
- **`sclk` period.** 2*CLK_DIV `clk` cycles.
- **Frame period.** 2*CLK_DIV*R `clk` cycles; 1536 with defaults.
- **Latency.**
  - Cycle T: sample event (`sclk` toggle).
  - T+1: integrators updated.
  - T+2: comb result registered into `pcm_data`; `pcm_valid` rises on that edge.
- **Latency, frame end to output.** 2 `clk` cycles from the channel-0 sample event that completes a frame to `pcm_valid`.
- **Stereo alignment.** Channel 1's last sample of a frame is the 0→1 event CLK_DIV cycles before channel 0's completing event.
- **Simultaneous events.** Load and accept in the same cycle: the new frame is loaded, `pcm_valid` stays 1 and no overrun is flagged.

## Configuration
- **Macro:** `PDM_RX_OVF_EN`.
- **Defined:** `ovf` is a sticky register, set on an overwrite of an unaccepted frame and cleared only by `rst`.
- **Undefined:** `ovf` is tied to 0 and no overwrite detection logic is built. Overwrite behaviour of `pcm_data` is unchanged.

## Test plan
- **Reset values:** `rst` held 5 cycles with `en` = 1 → all outputs 0. The first `sclk` rise occurs exactly 12 cycles after release, and `sclk` period is 24 cycles thereafter.
- **Mono full scale:** `dat_i` = 1 constantly, `pcm_ready` = 1 → from the 4th frame on, `pcm_data` = 0x4000 every 1536 cycles. `dat_i` = 0 constantly → 0xC000.
- **Stereo mapping:** CHANNELS=2, `dat_i` = 1 while `sclk` is high and 0 while low → steady `pcm_data` = {ch1 0xC000, ch0 0x4000}. Also check the 2-cycle latency after the completing 1→0 edge.
- **Cancellation:** `dat_i` alternating per channel-0 sample (+1, −1, …), mono → steady `pcm_data` = 0x0000.
- **Overrun:** `pcm_ready` held 0 across two frame periods → `pcm_valid` stays 1, `pcm_data` holds the second frame, and `ovf` = 1 until `rst`. With `PDM_RX_OVF_EN` undefined, `ovf` stays 0.
- **Disable:** `en` pulled low mid-frame for 100 cycles, then high → `sclk` = 0 throughout the gap, and the frame count restarts (3 transient frames, then 0x4000 with constant `dat_i` = 1). A simultaneous `rst` and frame load results in `pcm_valid` = 0.
